// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier pipeline: widths, accumulator states
// and the round/saturate helper used by the post-multiply stages.
package mul_pkg;

    localparam int MUL_M  = 26;
    localparam int MUL_N  = 13;
    localparam int MUL_PW = MUL_M + MUL_N;

    // Working width of the helper; callers zero-extend narrower sums into it.
    localparam int RND_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        ROUND,
        HOLD
    } acc_state_t;

    typedef struct packed {
        logic             sat;
        logic [RND_W-1:0] data;
    } rs_result_t;

    // Round-half-up by 2^-shift, then clamp to ow bits (or force clamp via sat_in).
    function automatic rs_result_t round_sat(
        input logic [RND_W-1:0] sum,
        input logic             sat_in,
        input int unsigned      shift,
        input int unsigned      ow
    );
        logic [RND_W:0] one;
        logic [RND_W:0] bias;
        logic [RND_W:0] r;
        logic [RND_W:0] mask;
        rs_result_t     res;
        one  = {{RND_W{1'b0}}, 1'b1};
        bias = '0;
        if (shift > 0) begin
            bias = one << (shift - 1);
        end
        r    = ({1'b0, sum} + bias) >> shift;
        mask = (one << ow) - one;
        if (sat_in || (r > mask)) begin
            res.sat  = 1'b1;
            res.data = mask[RND_W-1:0];
        end else begin
            res.sat  = 1'b0;
            res.data = r[RND_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/mul_accumulator_sat_round.sv
// Combinational rounding/scaling of the frame sum down to the output width,
// with saturation when the sum was already clamped or the result overflows.
module sat_round
    import mul_pkg::*;
#(
    parameter int AW    = 47,
    parameter int OW    = 32,
    parameter int SHIFT = 13
) (
    input  logic [AW-1:0] sum,
    input  logic          sat_in,
    output logic [OW-1:0] res,
    output logic          sat_out
);

    rs_result_t rs;
    logic       unused_hi;

    always_comb begin
        rs        = round_sat(RND_W'(sum), sat_in, SHIFT, OW);
        res       = rs.data[OW-1:0];
        sat_out   = rs.sat;
        unused_hi = ^rs.data[RND_W-1:OW];
    end

endmodule

// File: rtl/mul_accumulator.sv
// Frame accumulator behind the iterative multiplier: sums product beats until
// in_last, then emits a rounded, scaled, saturated result over valid/ready.
module mul_accumulator
    import mul_pkg::*;
#(
    parameter int M     = MUL_M,
    parameter int N     = MUL_N,
    parameter int SHIFT = 13,
    parameter int OW    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [M+N-1:0]   in_prod,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OW-1:0]    out_data,
    output logic             out_sat,
    output logic [7:0]       out_count
);

    localparam int PW = M + N;
    localparam int AW = PW + 8;

    acc_state_t    state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          sat_q, sat_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [OW-1:0] out_data_q, out_data_d;
    logic          out_sat_q, out_sat_d;
    logic [7:0]    out_count_q, out_count_d;

    logic [AW:0]   sum_ext;
    logic [OW-1:0] rs_data;
    logic          rs_sat;

    // One extra bit exposes accumulator overflow as the carry.
    assign sum_ext = {1'b0, acc_q} + {{(AW + 1 - PW){1'b0}}, in_prod};

    sat_round #(
        .AW    (AW),
        .OW    (OW),
        .SHIFT (SHIFT)
    ) u_sat_round (
        .sum     (acc_q),
        .sat_in  (sat_q),
        .res     (rs_data),
        .sat_out (rs_sat)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        out_count_d = out_count_q;
        case (state_q)
            IDLE, ACC: begin
                if (in_valid && in_ready_q) begin
                    if (sum_ext[AW]) begin
                        acc_d = '1;
                        sat_d = 1'b1;
                    end else begin
                        acc_d = sum_ext[AW-1:0];
                    end
                    cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                    state_d = in_last ? ROUND : ACC;
                end
            end
            ROUND: begin
                out_data_d  = rs_data;
                out_sat_d   = rs_sat;
                out_count_d = cnt_q;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Handshake flags follow the next state so they stay registered.
        in_ready_d  = (state_d == IDLE) || (state_d == ACC);
        out_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_count_q <= out_count_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_mul_accumulator.sv
// Self-checking bench: directed frames with literal results plus a randomized
// phase, all outputs compared against a plain-arithmetic frame-sum model.
module tb_mul_accumulator;

    localparam int SHIFT = 13;
    localparam longint unsigned AW_MAX = (64'd1 << 47) - 64'd1;
    localparam longint unsigned OW_MAX = 64'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0] d;
        logic        s;
        logic [7:0]  c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic [38:0] in_prod = '0;
    logic        in_ready, out_valid, out_sat;
    logic [31:0] out_data;
    logic [7:0]  out_count;

    logic        z_in_valid = 1'b0, z_in_last = 1'b0, z_out_ready = 1'b1;
    logic [38:0] z_in_prod = '0;
    logic        z_in_ready, z_out_valid, z_out_sat;
    logic [31:0] z_out_data;
    logic [7:0]  z_out_count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    mul_accumulator #(.SHIFT(SHIFT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_prod(in_prod),
        .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
        .out_count(out_count)
    );

    mul_accumulator #(.SHIFT(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .in_valid(z_in_valid), .in_prod(z_in_prod),
        .in_last(z_in_last), .in_ready(z_in_ready), .out_valid(z_out_valid),
        .out_ready(z_out_ready), .out_data(z_out_data), .out_sat(z_out_sat),
        .out_count(z_out_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Expected result of a frame from its plain arithmetic sum and beat count.
    function automatic exp_t model_result(input longint unsigned sum, input int beats);
        exp_t e;
        longint unsigned bias;
        longint unsigned r;
        bias = (SHIFT > 0) ? (64'd1 << (SHIFT - 1)) : 64'd0;
        e.c  = (beats > 255) ? 8'd255 : 8'(beats);
        r    = (sum + bias) >> SHIFT;
        if (sum > AW_MAX || r > OW_MAX) begin
            e.d = 32'hFFFF_FFFF;
            e.s = 1'b1;
        end else begin
            e.d = r[31:0];
            e.s = 1'b0;
        end
        return e;
    endfunction

    // Scoreboard monitor, sampled mid-cycle.
    exp_t            exp_q[$];
    longint unsigned m_sum = 0;
    int              m_cnt = 0;
    int              last_edge = -10;
    logic            prev_valid = 1'b0, prev_ready = 1'b0, prev_hs = 1'b0;
    logic [31:0]     prev_data = '0;
    logic            prev_sat = 1'b0;
    logic [7:0]      prev_count = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_sum = 0;
            m_cnt = 0;
            prev_valid = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (prev_hs) check("in_ready_after_handshake", 64'(in_ready), 64'd1);
            if (cyc == last_edge) check("round_in_ready", 64'(in_ready), 64'd0);
            if (in_valid && in_ready) begin
                m_sum += 64'(in_prod);
                m_cnt++;
                if (in_last) begin
                    exp_q.push_back(model_result(m_sum, m_cnt));
                    m_sum = 0;
                    m_cnt = 0;
                    last_edge = cyc + 1;
                end
            end
            if (out_valid) begin
                check("hold_in_ready", 64'(in_ready), 64'd0);
                if (!prev_valid) check("latency_edges", 64'(cyc + 1 - last_edge), 64'd2);
                if (prev_valid && !prev_ready) begin
                    check("stable_data", 64'(out_data), 64'(prev_data));
                    check("stable_sat", 64'(out_sat), 64'(prev_sat));
                    check("stable_count", 64'(out_count), 64'(prev_count));
                end
                if (out_ready) begin
                    $display("result data=0x%08h sat=%0d count=%0d", out_data, out_sat, out_count);
                    if (exp_q.size() == 0) begin
                        timeout("unexpected_result");
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("model_data", 64'(out_data), 64'(e.d));
                        check("model_sat", 64'(out_sat), 64'(e.s));
                        check("model_count", 64'(out_count), 64'(e.c));
                    end
                end
            end
            prev_hs    = out_valid && out_ready;
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_data  = out_data;
            prev_sat   = out_sat;
            prev_count = out_count;
        end
    end

    // Call at posedge+#1; returns at posedge+#1 after the beat is taken.
    task automatic send_beat(input logic [38:0] p, input logic l);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) timeout("send_beat");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic get_result(input logic [31:0] d, input logic s, input logic [7:0] c,
                              input string name, input int exp_wait);
        int t;
        t = 1;
        out_ready = 1'b1;
        @(negedge clk);
        while (!out_valid && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) begin
            timeout(name);
        end else begin
            if (exp_wait > 0) check({name, "_wait"}, 64'(t), 64'(exp_wait));
            check({name, "_data"}, 64'(out_data), 64'(d));
            check({name, "_sat"}, 64'(out_sat), 64'(s));
            check({name, "_count"}, 64'(out_count), 64'(c));
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [38:0] rand_prod();
        case ($urandom_range(0, 3))
            0:       return 39'h7F_FFFF_FFFF;
            1:       return 39'($urandom_range(0, 20000));
            default: return {7'($urandom), $urandom};
        endcase
    endfunction

    initial begin
        #(3_000_000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic will_acc;
        int   t;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // SHIFT=0 instance: plain sum, no rounding bias.
        z_in_valid = 1'b1; z_in_prod = 39'd5; z_in_last = 1'b0;
        t = 0;
        @(negedge clk);
        while (!z_in_ready && t < 50) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        z_in_prod = 39'd7; z_in_last = 1'b1;
        @(negedge clk);
        check("shift0_ready_second", 64'(z_in_ready), 64'd1);
        @(posedge clk); #1;
        z_in_valid = 1'b0; z_in_last = 1'b0;
        t = 0;
        @(negedge clk);
        while (!z_out_valid && t < 50) begin @(negedge clk); t++; end
        check("shift0_data", 64'(z_out_data), 64'd12);
        check("shift0_sat", 64'(z_out_sat), 64'd0);
        check("shift0_count", 64'(z_out_count), 64'd2);
        @(posedge clk); #1;

        send_beat(39'd1364555812, 1'b1);
        get_result(32'd166572, 1'b0, 8'd1, "single", 2);

        send_beat(39'd1364555812, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        send_beat(39'd1364555812, 1'b1);
        get_result(32'd333144, 1'b0, 8'd2, "gap", -1);

        for (int i = 0; i < 128; i++) send_beat(39'h7F_FFFF_FFFF, (i == 127));
        get_result(32'hFFFF_FFFF, 1'b1, 8'd128, "saturate", -1);
        send_beat(39'd8192, 1'b1);
        get_result(32'd1, 1'b0, 8'd1, "after_sat", -1);

        // Backpressure with a beat waiting upstream.
        out_ready = 1'b0;
        send_beat(39'd8192, 1'b1);
        in_valid = 1'b1; in_prod = 39'd16384; in_last = 1'b1;
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 50) begin @(negedge clk); t++; end
        for (int k = 0; k < 5; k++) begin
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_data", 64'(out_data), 64'd1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_ready_after_hs", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        get_result(32'd2, 1'b0, 8'd1, "bp_held_beat", -1);

        // Asynchronous reset in the middle of a frame.
        for (int i = 0; i < 3; i++) send_beat(39'd100000, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_sat", 64'(out_sat), 64'd0);
        check("rst_out_count", 64'(out_count), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        send_beat(39'd4096, 1'b1);
        get_result(32'd1, 1'b0, 8'd1, "after_reset", 2);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            will_acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (!in_valid || will_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_prod  = rand_prod();
                in_last  = ($urandom_range(0, 3) == 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
        send_beat(rand_prod(), 1'b1);
        t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 100) begin
            @(posedge clk);
            t++;
        end
        if (exp_q.size() != 0) timeout("drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mul_accumulator.md
# mul_accumulator

- Downstream consumer of the iterative `multiplier` stage.
- Function:
  - Takes unsigned `M+N`-bit products one beat at a time over a valid/ready handshake.
  - Sums the beats of each frame (the frame ends on the beat flagged `in_last`) into a wide accumulator.
  - Rounds the sum and scales it by `2^-SHIFT` to an `OW`-bit result, saturating if it does not fit.
  - Presents the result on a valid/ready output port.
- Use: dot-product and filter-tap sums built from successive multiplier results.

## Interface
Parameters:
- `M`, 26: multiplicand width, matching the multiplier.
- `N`, 13: multiplier width, matching the multiplier.
- `SHIFT`, 13: right shift applied to the frame sum. 0 is legal and means no rounding.
- `OW`, 32: result width.
- `AW`, `M+N+8`: accumulator width (local; not overridable).

Ports (all outputs registered):
- `clk`, input, 1: clock. Everything is rising-edge.
- `rst_n`, input, 1: reset. Asynchronous, active-low.
- `in_valid`, input, 1: product beat valid.
- `in_prod`, input, `M+N`: unsigned product.
- `in_last`, input, 1: marks the final beat of a frame.
- `in_ready`, output, 1: block can accept a beat.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: downstream accepts the result.
- `out_data`, output, `OW`: rounded, scaled, saturated frame sum.
- `out_sat`, output, 1: set if the result saturated.
- `out_count`, output, 8: number of beats in the frame, saturating at 255.

## Operation
State machine with states `IDLE`, `ACC`, `ROUND`, `HOLD`.

- **`IDLE` / `ACC`** (`in_ready`=1):
  - On a beat (`in_valid` && `in_ready`): `acc <= acc + in_prod`; `cnt <= min(cnt+1, 255)`; state moves to `ACC`.
  - If the addition would exceed `2^AW-1`, then `acc` is held at all-ones and the sticky bit `sat_i` is set.
  - A beat with `in_last`=1 moves to `ROUND`; this includes a frame that is only one beat long.
- **`ROUND`** (`in_ready`=0, single cycle):
  - `r = (acc + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >> SHIFT`, computed at `AW+1` bits. This is round-half-up.
  - If `sat_i` is set or `r > 2^OW-1`: `out_data` = all-ones and `out_sat`=1.
  - Otherwise: `out_data = r[OW-1:0]` and `out_sat`=0.
  - `out_count <= cnt`. Next state is `HOLD`.
- **`HOLD`** (`out_valid`=1, `in_ready`=0):
  - `out_data`, `out_sat` and `out_count` stay stable until `out_ready`=1.
  - On handshake: `acc`, `cnt` and `sat_i` clear, `out_valid` drops and the state returns to `IDLE`.
- A beat offered while in `ROUND` or `HOLD` is not accepted. The upstream holds it, per valid/ready rules.
- `in_valid`=0 in `ACC` leaves all state unchanged; a frame may have idle gaps.
- Reset (at any time, including mid-frame or in `HOLD`):
  - State goes to `IDLE`; `acc`, `cnt`, `sat_i` are cleared.
  - Output reset values: `out_valid`=0, `in_ready`=0 while `rst_n`=0 then 1 from the first clock edge after deassertion, `out_data`=0, `out_sat`=0, `out_count`=0.
  - A partially accumulated frame is discarded.

## Timing
- Last beat accepted at edge t: `ROUND` occupies cycle t+1 and `out_valid`=1 from edge t+2.
- Minimum frame period is 3 cycles for a 1-beat frame (with `out_ready` held high).
- Input throughput is 1 beat/cycle within a frame.
- Output handshake at edge h: `in_ready`=1 from edge h+1.
- No combinational path from inputs to outputs.

## Structure
- Shared package `mul_pkg`:
  - Constants `MUL_M`=26, `MUL_N`=13, `MUL_PW`=`M+N`.
  - State enum `acc_state_t`.
  - Round/saturate helper function, also reused by future stages.
- One natural sub-module: `sat_round`.
  - Combinational: `AW`-bit sum plus `sat_i` in; `OW`-bit result and saturation flag out.
  - Its output is registered in `ROUND`.
- The FSM, accumulator and counter stay in `mul_accumulator`.

## Test plan
- **Single-beat frame.**
  - Stimulus: `in_prod`=1364555812 (=0x050A01*0x1024), `in_last`=1.
  - Required: `out_data`=166572, `out_sat`=0, `out_count`=1, `out_valid` exactly 2 cycles after the accepted beat.
- **Two-beat frame with a gap.**
  - Stimulus: the same product twice, 3 idle cycles between the beats, `in_last` on the second.
  - Required: `out_data`=333144, `out_count`=2.
- **Saturation.**
  - Stimulus: 128 beats of `2^39-1`.
  - Required: `out_data`=0xFFFFFFFF, `out_sat`=1, `out_count`=128.
  - Next frame (one beat of 8192): `out_data`=1, `out_sat`=0, confirming the sticky bit was cleared.
- **Backpressure.**
  - Stimulus: `out_ready`=0 for 5 cycles in `HOLD` while upstream asserts `in_valid`.
  - Required: `out_data` stable, `in_ready`=0, no beat accepted. After the handshake, the held beat is accepted on the next cycle.
- **Reset mid-frame.**
  - Stimulus: assert `rst_n`=0 asynchronously after 3 beats.
  - Required: all outputs go to their reset values immediately. A subsequent 1-beat frame of 4096 gives `out_data`=1 (`SHIFT`=13), `out_count`=1.
- **`SHIFT`=0 build.**
  - Stimulus: beats 5 and 7.
  - Required: `out_data`=12, with no rounding bias.
